// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the generator and checker.
// Polynomial x^8+x^7+x^5+x^3+1 (0xA9), data shifted LSB first.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY = 8'hA9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One serial step: shift the data bit in, fold the poly when the MSB falls out.
  function automatic logic [7:0] crc8_step(input logic [7:0] cur, input logic b);
    return {cur[6:0], b} ^ (cur[7] ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_lfsr_step.sv
// Combinational single-bit CRC-8 LFSR step, shared by generator and checker.
module crc8_lfsr_step
  import crc8_pkg::*;
(
  input  logic [7:0] cur,
  input  logic       din,
  output logic [7:0] nxt
);

  // Next LFSR value for one incoming data bit.
  always_comb begin
    nxt = crc8_step(cur, din);
  end

endmodule

// File: rtl/crc8_checker.sv
// Receive-side CRC-8 checker. Accumulates the CRC over the words of a frame
// and, on the last word, compares it with the received CRC byte.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; running CRC held between words
// SHIFT | one data bit per cycle through the LFSR, LSB first
// DONE  | done_o pulse; reload seed if this was the frame's last word
module crc8_checker
  import crc8_pkg::*;
#(
  parameter int DATA_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic [7:0]        crc_i,
  input  logic [7:0]        init_val,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              crc_ok_o,
  output logic              crc_err_o,
  output logic [7:0]        calc_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic [7:0]        rx_crc_q;
  logic [7:0]        calc_q;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        step_out;

  crc8_lfsr_step u_step (
    .cur (calc_q),
    .din (data_q[cnt]),
    .nxt (step_out)
  );

  // Word FSM: capture, serial shift, then flag the result on the final bit.
  // The ok/err decision uses the post-shift value so it matches calc_o in DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      data_q    <= '0;
      last_q    <= 1'b0;
      rx_crc_q  <= 8'h00;
      calc_q    <= init_val;
      cnt       <= '0;
      done_o    <= 1'b0;
      crc_ok_o  <= 1'b0;
      crc_err_o <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      crc_ok_o  <= 1'b0;
      crc_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            data_q   <= data_i;
            last_q   <= last_i;
            rx_crc_q <= crc_i;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          calc_q <= step_out;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state  <= DONE;
            done_o <= 1'b1;
            if (last_q) begin
              crc_ok_o  <= (step_out == rx_crc_q);
              crc_err_o <= (step_out != rx_crc_q);
            end
          end
        end
        DONE: begin
          if (last_q) calc_q <= init_val;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);
  assign calc_o = calc_q;

endmodule
